// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer in front of sdram_controller, with a timeout watchdog.
// Define SDRAM_ARB_RR_EN for round-robin on ties; otherwise port 0 has fixed priority.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [DATA_WIDTH-1:0] sd_wr_data,
    output logic                  sd_wr_enable,
    output logic                  sd_rd_enable,
    input  logic                  sd_ack,
    input  logic                  sd_busy,
    input  logic                  sd_rd_ready,
    input  logic [DATA_WIDTH-1:0] sd_rd_data,
    output logic                  timeout_flag
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, DONE} state_t;

    state_t      state;
    logic        sel;
    logic        we_q;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_next;
    logic        tmo_hit;
    logic        grant1;

    assign tmo_next = tmo_cnt + 16'd1;
    assign tmo_hit  = (tmo_next == 16'(TIMEOUT));

`ifdef SDRAM_ARB_RR_EN
    // last_sel resets to 1 so the first tie goes to port 0.
    logic last_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_sel <= 1'b1;
        end else if (state == IDLE && (req0 || req1)) begin
            last_sel <= grant1;
        end
    end

    assign grant1 = (req0 && req1) ? ~last_sel : req1;
`else
    assign grant1 = ~req0 & req1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel          <= 1'b0;
            we_q         <= 1'b0;
            tmo_cnt      <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            sd_addr      <= '0;
            sd_wr_data   <= '0;
            sd_wr_enable <= 1'b0;
            sd_rd_enable <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel          <= grant1;
                        we_q         <= grant1 ? we1 : we0;
                        sd_addr      <= grant1 ? addr1 : addr0;
                        sd_wr_data   <= grant1 ? wdata1 : wdata0;
                        sd_wr_enable <= grant1 ? we1 : we0;
                        sd_rd_enable <= grant1 ? ~we1 : ~we0;
                        tmo_cnt      <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE, WAIT_WR, WAIT_RD: begin
                    tmo_cnt <= tmo_next;
                    if (state == ISSUE && sd_ack) begin
                        sd_wr_enable <= 1'b0;
                        sd_rd_enable <= 1'b0;
                        state        <= we_q ? WAIT_WR : WAIT_RD;
                    end else if ((state == WAIT_WR && !sd_busy) ||
                                 (state == WAIT_RD && sd_rd_ready)) begin
                        if (state == WAIT_RD) begin
                            if (sel) rdata1 <= sd_rd_data;
                            else     rdata0 <= sd_rd_data;
                        end
                        done0 <= ~sel;
                        done1 <= sel;
                        state <= DONE;
                    end else if (tmo_hit) begin
                        // Abort: release the controller and report the error to the owner.
                        sd_wr_enable <= 1'b0;
                        sd_rd_enable <= 1'b0;
                        done0        <= ~sel;
                        done1        <= sel;
                        err0         <= ~sel;
                        err1         <= sel;
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and sequencer between SDRAM requesters and the single-port `sdram_controller`. It serialises byte reads and writes from a host port (port 0, GPMC register logic) and an auxiliary port (port 1, DMA/stream logic) onto the controller's shared `wr_*`/`rd_*` command interface. It owns the enable/ack/busy/rd_ready handshake and returns completions and read data to the originating port. A timeout watchdog keeps a hung controller from wedging either requester.

## Interface
- `ADDR_WIDTH`, 25: SDRAM byte address width.
- `DATA_WIDTH`, 8: SDRAM data width.
- `TIMEOUT`, 1023: max cycles from command issue to completion before abort; 16-bit counter, legal range 1..65535.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request; held high with fields stable until matching `done`.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_WIDTH  byte address.
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `err0`, `err1`  out  1  valid with `done`; 1 = aborted by timeout.
- `rdata0`, `rdata1`  out  DATA_WIDTH  last read data for that port; held until that port's next read completes.
- `sd_addr`  out  ADDR_WIDTH  drives controller `wr_addr` and `rd_addr`.
- `sd_wr_data`  out  DATA_WIDTH  controller write data.
- `sd_wr_enable`, `sd_rd_enable`  out  1  controller command strobes.
- `sd_ack`, `sd_busy`, `sd_rd_ready`  in  1  controller handshake.
- `sd_rd_data`  in  DATA_WIDTH  controller read data.
- `timeout_flag`  out  1  sticky; set on any timeout, cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_WR, WAIT_RD, DONE.
- IDLE: with any `req` high, select a port, latch `sel`, `we`, `addr`, `wdata` into `sd_*` registers, assert the enable for the chosen direction, then go to ISSUE.
- ISSUE: hold the enable until `sd_ack` is sampled high. Drop the enable on the next edge. Go to WAIT_WR (write) or WAIT_RD (read).
- WAIT_WR: wait for `sd_busy`=0, sampled at least one cycle after ack, then go to DONE.
- WAIT_RD: on `sd_rd_ready`=1, capture `sd_rd_data` into `rdata<sel>`, then go to DONE.
- DONE: pulse `done<sel>` for exactly one cycle with `err<sel>`=0, then return to IDLE. The next grant is decided in IDLE, so there is at least one IDLE cycle between transactions.
- Arbitration is evaluated only in IDLE. A granted transaction always runs to completion or timeout. If a requester drops `req` mid-transaction, the drop is ignored and `done` still pulses.
- Timeout: a 16-bit counter clears on entry to ISSUE and increments in ISSUE, WAIT_WR and WAIT_RD. When it reaches `TIMEOUT`:
  - drop both enables;
  - go to DONE with `err<sel>`=1;
  - leave `rdata` unchanged;
  - set `timeout_flag`.
- `sd_ack`, `sd_busy` and `sd_rd_ready` are ignored in states where they are not expected.

## Timing
- Reset values: all outputs 0, state IDLE, round-robin pointer favours port 0.
- Reset asserted mid-transaction clears enables and `done` immediately (asynchronous). No completion is reported for the aborted transaction.
- `req` sampled at edge N → enable high after edge N+1 (1-cycle issue latency).
- `sd_ack` sampled at edge M → enable low after edge M+1.
- Read: `sd_rd_ready` sampled at edge R → `rdata` updated and `done` high after edge R+1.
- Write: `sd_busy`=0 sampled at edge B → `done` after edge B+1.
- Back-to-back requests from one port: the next enable rises no earlier than 2 cycles after the previous `done`.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin. On a simultaneous `req0`/`req1`, grant the port not served last. The pointer updates on each grant.
- `SDRAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins a tie. Port 1 can starve. The pointer logic is removed.

## Test plan
- Port 0 writes 0xA5 to 0x0000123, controller acks after 3 cycles and drops busy 4 cycles later → one `sd_wr_enable` held until ack, `sd_addr`=0x0000123, single `done0` with `err0`=0.
- Port 1 reads 0x1FFFFFF, controller returns 0x3C with `sd_rd_ready` → `rdata1`=0x3C, `done1` pulses once, `rdata0` unchanged.
- Both ports request reads continuously for 4 transactions:
  - with `SDRAM_ARB_RR_EN`, grant order 0,1,0,1;
  - without it, order 0,0,0,0 while `req0` stays high.
- Port 0 write arrives while a port 1 read is in WAIT_RD → port 0 is not granted until after `done1`; grant follows in the next IDLE cycle.
- `TIMEOUT`=8, controller never acks → enable drops after 8 cycles in ISSUE, `done0` with `err0`=1, `timeout_flag`=1; a following transaction completes normally.
- `rst_n` pulsed low during WAIT_RD → outputs 0 immediately; no `done` afterwards; a new request after release completes normally.
